// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
// Build option: define ID_EX_FWD_EN to enable the forwarding muxes (otherwise any EX-stage RAW hazard stalls).
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_imm_zext,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              stall,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_wr_addr,
  input  logic [DATA_W-1:0] exm_alu_out,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_wr_addr,
  input  logic [DATA_W-1:0] mwb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_wr_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_valid,
  output logic              load_use_stall
);

  // Valid semantics: ex_valid marks a real instruction in EX; a bubble has
  // ex_valid = 0 and all control bits 0, so downstream never needs to gate them.
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs_addr;
  logic [REG_AW-1:0] ex_rt_addr;
  logic [3:0]        ex_alu_ctrl;
  logic              ex_alu_src;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              addr_match;
  logic              ex_writer;

  assign imm_ext = id_imm_zext ? {{(DATA_W-IMM_W){1'b0}}, id_imm}
                               : {{(DATA_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};

  // Priority: reset > flush > stall > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs_addr    <= '0;
      ex_rt_addr    <= '0;
      ex_wr_addr    <= '0;
      ex_alu_ctrl   <= 4'b0000;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (flush) begin
      ex_valid      <= 1'b0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs_addr    <= '0;
      ex_rt_addr    <= '0;
      ex_wr_addr    <= '0;
      ex_alu_ctrl   <= 4'b0000;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm        <= imm_ext;
      ex_rs_addr    <= id_rs_addr;
      ex_rt_addr    <= id_rt_addr;
      ex_wr_addr    <= id_wr_addr;
      ex_alu_ctrl   <= id_alu_ctrl;
      ex_alu_src    <= id_alu_src;
      ex_reg_write  <= id_reg_write  & id_valid;
      ex_mem_read   <= id_mem_read   & id_valid;
      ex_mem_write  <= id_mem_write  & id_valid;
      ex_mem_to_reg <= id_mem_to_reg & id_valid;
    end
  end

`ifdef ID_EX_FWD_EN
  logic exm_hit_rs, exm_hit_rt, mwb_hit_rs, mwb_hit_rt;

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign exm_hit_rs = exm_reg_write && (exm_wr_addr != '0) && (exm_wr_addr == ex_rs_addr);
  assign exm_hit_rt = exm_reg_write && (exm_wr_addr != '0) && (exm_wr_addr == ex_rt_addr);
  assign mwb_hit_rs = mwb_reg_write && (mwb_wr_addr != '0) && (mwb_wr_addr == ex_rs_addr);
  assign mwb_hit_rt = mwb_reg_write && (mwb_wr_addr != '0) && (mwb_wr_addr == ex_rt_addr);

  always_comb begin
    fwd_rs = ex_rs_data;
    if (exm_hit_rs)      fwd_rs = exm_alu_out;
    else if (mwb_hit_rs) fwd_rs = mwb_data;
  end

  always_comb begin
    fwd_rt = ex_rt_data;
    if (exm_hit_rt)      fwd_rt = exm_alu_out;
    else if (mwb_hit_rt) fwd_rt = mwb_data;
  end

  // Only a load result is too late to forward; ALU results reach EX via EX/MEM.
  assign ex_writer = ex_mem_read;
`else
  logic unused_fwd;

  assign unused_fwd = &{1'b0, exm_reg_write, exm_wr_addr, exm_alu_out,
                        mwb_reg_write, mwb_wr_addr, mwb_data, ex_rs_addr, ex_rt_addr};
  assign fwd_rs     = ex_rs_data;
  assign fwd_rt     = ex_rt_data;
  // Without forwarding every producer in EX must hold decode back.
  assign ex_writer  = ex_reg_write;
`endif

  assign addr_match = (ex_wr_addr == id_rs_addr) || (id_uses_rt && (ex_wr_addr == id_rt_addr));
  assign load_use_stall = ex_valid && ex_writer && (ex_wr_addr != '0) && addr_match;

  assign alu_a         = fwd_rs;
  assign alu_b         = ex_alu_src ? ex_imm : fwd_rt;
  assign alu_ctrl      = ex_alu_ctrl;
  assign ex_store_data = fwd_rt;

endmodule
